// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Moore-style control FSM for a multicycle datapath. Each instruction walks
// FETCH -> DECODE -> EXEC and then, depending on its class, MEM and/or WB
// before returning to FETCH. HALT and ERR are absorbing until reset.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   run            enables instruction fetch (only looked at in FETCH)
//   opcode[5:0]    instruction opcode, latched at the end of DECODE
//   flags[2:0]     ALU flags: [0]=zero, [1]=carry, [2]=sign
//   mem_ready      data memory completion strobe
//   RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect
//                  datapath controls
//   ALUop[2:0]     ALU operation, ALUinSel[1:0] ALU B-input select
//   ir_load        latch instruction register
//   pc_en, pc_src  advance PC / select branch target
//   state[2:0]     current FSM state (debug)
//   halted, err    sitting in HALT / ERR
//   instr_retired  count of pc_en cycles, wraps at 16 bits
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [2:0]  flags,
    input  logic        mem_ready,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        DataPCSel,
    output logic        RegSelect,
    output logic [2:0]  ALUop,
    output logic [1:0]  ALUinSel,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_src,
    output logic [2:0]  state,
    output logic        halted,
    output logic        err,
    output logic [15:0] instr_retired
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    // Wait-count value of the last MEM cycle in which mem_ready is still accepted.
    localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StErr    = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsRegReg,
        ClsRegImm,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsHalt,
        ClsIllegal
    } cls_e;

    function automatic cls_e classify(input logic [5:0] op);
        cls_e c;
        c = ClsIllegal;
        if (op[5:3] == 3'b000) begin
            c = ClsRegReg;
        end else if (op[5:3] == 3'b001) begin
            c = ClsRegImm;
        end else if (op == 6'b010000) begin
            c = ClsLoad;
        end else if (op == 6'b011000) begin
            c = ClsStore;
        end else if (op[5:3] == 3'b100 && op[2:0] <= 3'd4) begin
            c = ClsBranch;
        end else if (op == 6'b111111) begin
            c = ClsHalt;
        end
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [15:0]      instr_retired_q;
    cls_e             cls_live;
    cls_e             cls_q;
    logic             taken;

    // DECODE routes on the incoming opcode; later states use the latched copy.
    assign cls_live = classify(opcode);
    assign cls_q    = classify(opcode_q);

    always_comb begin
        taken = 1'b0;
        case (opcode_q[2:0])
            3'd0:    taken = 1'b1;
            3'd1:    taken = flags[0];
            3'd2:    taken = ~flags[0];
            3'd3:    taken = flags[1];
            3'd4:    taken = flags[2];
            default: taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StFetch;
            opcode_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = '0;
        unique case (state_q)
            StFetch: begin
                if (run) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                opcode_d = opcode;
                case (cls_live)
                    ClsHalt:    state_d = StHalt;
                    ClsIllegal: state_d = StErr;
                    default:    state_d = StExec;
                endcase
            end
            StExec: begin
                case (cls_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch:         state_d = StFetch;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsStore) ? StFetch : StWb;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    // Output logic
    always_comb begin
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        DataPCSel = 1'b0;
        RegSelect = 1'b0;
        ALUop     = 3'b000;
        ALUinSel  = 2'b00;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        unique case (state_q)
            StFetch: begin
                // No fetch while reset is held, so outputs stay quiet then.
                ir_load = run & reset;
            end
            StExec: begin
                case (cls_q)
                    ClsRegReg: begin
                        ALUop    = opcode_q[2:0];
                        ALUinSel = 2'b00;
                    end
                    ClsRegImm: begin
                        ALUop    = opcode_q[2:0];
                        ALUinSel = 2'b01;
                    end
                    ClsLoad, ClsStore: begin
                        ALUop    = 3'b000;
                        ALUinSel = 2'b01;
                    end
                    ClsBranch: begin
                        ALUinSel = 2'b00;
                        pc_en    = 1'b1;
                        pc_src   = taken;
                    end
                    default: begin
                    end
                endcase
            end
            StMem: begin
                MemRead  = (cls_q == ClsLoad);
                MemWrite = (cls_q == ClsStore);
                pc_en    = (cls_q == ClsStore) & mem_ready;
            end
            StWb: begin
                RegWrite  = 1'b1;
                pc_en     = 1'b1;
                MemtoReg  = (cls_q == ClsLoad);
                RegSelect = (cls_q == ClsRegImm) | (cls_q == ClsLoad);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_retired_q <= '0;
        end else if (pc_en) begin
            instr_retired_q <= instr_retired_q + 16'd1;
        end
    end

    assign state         = state_q;
    assign halted        = (state_q == StHalt);
    assign err           = (state_q == StErr);
    assign instr_retired = instr_retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int unsigned MemTimeout = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [5:0]  opcode;
    logic [2:0]  flags;
    logic        mem_ready;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect;
    logic [2:0]  ALUop;
    logic [1:0]  ALUinSel;
    logic        ir_load, pc_en, pc_src;
    logic [2:0]  state;
    logic        halted, err;
    logic [15:0] instr_retired;

    multicycle_controller #(.MEM_TIMEOUT(MemTimeout)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .flags         (flags),
        .mem_ready     (mem_ready),
        .RegWrite      (RegWrite),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemtoReg      (MemtoReg),
        .DataPCSel     (DataPCSel),
        .RegSelect     (RegSelect),
        .ALUop         (ALUop),
        .ALUinSel      (ALUinSel),
        .ir_load       (ir_load),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .state         (state),
        .halted        (halted),
        .err           (err),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    // Expected outcome of one instruction, from its fetch to its retirement
    // (pc_en) or to the absorbing HALT/ERR state.
    typedef struct {
        bit          terminal;
        int          term_state;
        int          lat;
        int          mem_cycles;
        bit          mem_is_read;
        bit          chk_sel;
        bit          chk_op;
        int          alu_op;
        int          alu_in_sel;
        bit          pc_src;
        bit          reg_write;
        bit          mem_to_reg;
        bit          reg_select;
        logic [15:0] retired_before;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] model_retired;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Reference model: instruction class from plain arithmetic on the opcode.
    function automatic exp_t model(input int op, input int fl, input int n,
                                   input logic [15:0] retired);
        exp_t e;
        int   hi;
        int   lo;
        bit   in_time;
        hi      = op / 8;
        lo      = op % 8;
        in_time = (n >= 1) && (n <= int'(MemTimeout));
        e = '{default: 0};
        e.retired_before = retired;
        if (hi <= 1) begin
            e.lat        = 4;
            e.chk_sel    = 1;
            e.chk_op     = 1;
            e.alu_op     = lo;
            e.alu_in_sel = hi;
            e.reg_write  = 1;
            e.reg_select = (hi == 1);
        end else if (op == 16 || op == 24) begin
            e.chk_sel     = 1;
            e.chk_op      = 1;
            e.alu_op      = 0;
            e.alu_in_sel  = 1;
            e.mem_is_read = (op == 16);
            if (in_time) begin
                e.mem_cycles = n;
                if (op == 16) begin
                    e.lat        = 4 + n;
                    e.reg_write  = 1;
                    e.mem_to_reg = 1;
                    e.reg_select = 1;
                end else begin
                    e.lat = 3 + n;
                end
            end else begin
                e.terminal   = 1;
                e.term_state = 6;
                e.mem_cycles = int'(MemTimeout);
                e.lat        = 3 + int'(MemTimeout) + 1;
            end
        end else if (hi == 4 && lo <= 4) begin
            e.lat        = 3;
            e.chk_sel    = 1;
            e.alu_in_sel = 0;
            case (lo)
                0:       e.pc_src = 1;
                1:       e.pc_src = ((fl & 1) != 0);
                2:       e.pc_src = ((fl & 1) == 0);
                3:       e.pc_src = ((fl & 2) != 0);
                default: e.pc_src = ((fl & 4) != 0);
            endcase
        end else if (op == 63) begin
            e.terminal   = 1;
            e.term_state = 5;
            e.lat        = 3;
        end else begin
            e.terminal   = 1;
            e.term_state = 6;
            e.lat        = 3;
        end
        return e;
    endfunction

    // Monitor: counts cycles from ir_load and compares when the instruction ends.
    int mon_cyc = 0;
    int mon_mem = 0;
    bit mon_active = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            mon_active = 0;
        end else begin
            if (ir_load) begin
                mon_active = 1;
                mon_cyc    = 1;
                mon_mem    = 0;
            end else if (mon_active) begin
                mon_cyc++;
            end
            if (mon_active) begin
                if (exp_q.size() == 0) begin
                    if (pc_en || halted || err) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected completion: state=%0d pc_en=%0d, want none",
                                 state, pc_en);
                        mon_active = 0;
                    end
                end else begin
                    e = exp_q[0];
                    if (MemRead || MemWrite) begin
                        mon_mem++;
                        check("mem direction", MemRead, e.mem_is_read);
                        check("mem exclusive", MemRead & MemWrite, 0);
                    end
                    if (state == 3'd2) begin
                        if (e.chk_sel) check("ALUinSel", ALUinSel, e.alu_in_sel);
                        if (e.chk_op) check("ALUop", ALUop, e.alu_op);
                    end
                    if (pc_en || halted || err) begin
                        e = exp_q.pop_front();
                        check("latency", mon_cyc, e.lat);
                        check("mem cycles", mon_mem, e.mem_cycles);
                        check("terminal", halted | err, e.terminal);
                        if (e.terminal) begin
                            check("end state", state, e.term_state);
                            check("halted", halted, e.term_state == 5);
                            check("err", err, e.term_state == 6);
                            check("mem idle at end", MemRead | MemWrite, 0);
                            check("pc_en at end", pc_en, 0);
                        end else begin
                            check("pc_src", pc_src, e.pc_src);
                            check("RegWrite", RegWrite, e.reg_write);
                            check("MemtoReg", MemtoReg, e.mem_to_reg);
                            check("RegSelect", RegSelect, e.reg_select);
                            check("DataPCSel", DataPCSel, 0);
                            check("instr_retired", instr_retired, e.retired_before);
                        end
                        mon_active = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) begin
            run       = 1'b0;
            opcode    = 6'($urandom);
            flags     = 3'($urandom);
            mem_ready = 1'($urandom);
            step();
        end
    endtask

    // Drives one instruction from its FETCH cycle; abort_at>0 stops early so
    // the caller can reset in that cycle.
    task automatic issue(input logic [5:0] op, input logic [2:0] fl, input int n,
                         input int abort_at);
        exp_t e;
        bit   is_mem;
        int   span;
        e = model(int'(op), int'(fl), n, model_retired);
        exp_q.push_back(e);
        if (!e.terminal) model_retired = model_retired + 16'd1;
        is_mem = (op == 6'b010000) || (op == 6'b011000);
        span   = (n >= 1 && n <= int'(MemTimeout)) ? n : int'(MemTimeout);
        for (int k = 1; k <= e.lat; k++) begin
            if (k == abort_at) return;
            run    = (k == 1) ? 1'b1 : 1'($urandom % 2);
            opcode = (k <= 2) ? op : 6'($urandom);
            flags  = (k == 3) ? fl : 3'($urandom);
            if (is_mem && k >= 4 && k <= 3 + span) mem_ready = (k == 3 + n);
            else mem_ready = 1'($urandom);
            step();
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b0;
        step();
        check("rst state", state, 0);
        check("rst MemRead", MemRead, 0);
        check("rst MemWrite", MemWrite, 0);
        check("rst instr_retired", instr_retired, 0);
        check("rst halted", halted, 0);
        check("rst err", err, 0);
        check("rst ir_load", ir_load, 0);
        check("rst pc_en", pc_en, 0);
        exp_q.delete();
        model_retired = 16'd0;
        reset = 1'b1;
        run   = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: no finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [5:0] op;
        int         n;
        reset         = 1'b0;
        run           = 1'b0;
        opcode        = 6'd0;
        flags         = 3'd0;
        mem_ready     = 1'b0;
        model_retired = 16'd0;
        step();
        do_reset();

        idle(3);
        check("idle state", state, 0);
        check("idle ir_load", ir_load, 0);

        issue(6'b000001, 3'b000, 0, 0);
        issue(6'b010000, 3'($urandom), 3, 0);
        issue(6'b100001, 3'b001, 0, 0);
        issue(6'b100001, 3'b000, 0, 0);
        issue(6'b011000, 3'($urandom), int'(MemTimeout), 0);
        issue(6'b010000, 3'($urandom), int'(MemTimeout), 0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0:       op = {3'b000, 3'($urandom)};
                1:       op = {3'b001, 3'($urandom)};
                2:       op = 6'b010000;
                3:       op = 6'b011000;
                default: op = {3'b100, 3'($urandom_range(0, 4))};
            endcase
            n = ($urandom % 8 == 0) ? int'(MemTimeout) : int'($urandom_range(1, 4));
            issue(op, 3'($urandom), n, 0);
            if ($urandom % 4 == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        check("retired after random", instr_retired, model_retired);

        // Reset while a load waits in MEM.
        issue(6'b010000, 3'd0, 10, 5);
        do_reset();

        // Store with mem_ready never arriving.
        issue(6'b011000, 3'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run = 1'b1;
            check("timeout err held", err, 1);
            check("timeout state", state, 6);
            check("timeout MemWrite", MemWrite, 0);
            step();
        end
        do_reset();

        issue(6'b101000, 3'd0, 0, 0);
        check("illegal err held", err, 1);
        do_reset();

        issue(6'b111111, 3'd0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            run    = 1'b1;
            opcode = 6'($urandom);
            check("halt held", halted, 1);
            check("halt state", state, 5);
            check("halt ir_load", ir_load, 0);
            check("halt pc_en", pc_en, 0);
            step();
        end
        do_reset();

        // Preload the count near the top so the 16-bit wrap is reached quickly.
        force dut.instr_retired_q = 16'hFFFE;
        idle(1);
        release dut.instr_retired_q;
        model_retired = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            issue({3'b100, 3'($urandom_range(0, 4))}, 3'($urandom), 0, 0);
        end
        idle(1);
        check("retired wrap", instr_retired, model_retired);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
